l1_set_assoc_cache: RTL and testbench

- First-level data cache between the load/store unit and the next cache level.
- 2-way set-associative, one 32-bit word per line, write-back, write-allocate, LRU replacement.
- On a miss it stalls the requester (busy) and runs a writeback/fill handshake with the lower level.

---
 rtl/l1_set_assoc_cache.sv | 173 +++++++++++++++++
 tb/tb_l1_set_assoc_cache.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/l1_set_assoc_cache.sv
// rtl/l1_set_assoc_cache.sv - 2-way set-associative write-back L1 data cache, one word per line.
// Optional hit/miss counters enabled by L1_PERF_COUNTERS_EN.
module l1_set_assoc_cache #(
    parameter int DATA_WIDTH = 32,
    parameter int SET_WIDTH  = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic                  store,
    input  logic [31:0]           address,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [DATA_WIDTH-1:0] mem_data,
    input  logic                  mem_ready,
    output logic                  hit,
    output logic                  miss,
    output logic                  mem_write,
    output logic                  mem_read,
    output logic [31:0]           mem_addr,
    output logic                  busy,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic [DATA_WIDTH-1:0] mem_write_data
`ifdef L1_PERF_COUNTERS_EN
    ,
    output logic [31:0]           hit_count,
    output logic [31:0]           miss_count
`endif
);

    localparam int SETS  = 1 << SET_WIDTH;
    localparam int TAG_W = 32 - SET_WIDTH - 2;

    typedef enum logic [1:0] {S_IDLE, S_WRITEBACK, S_FILL} state_t;

    state_t                state_q, state_d;
    logic [1:0]            valid_q [SETS];
    logic [1:0]            valid_d [SETS];
    logic [1:0]            dirty_q [SETS];
    logic [1:0]            dirty_d [SETS];
    logic [TAG_W-1:0]      tag_q   [SETS][2];
    logic [TAG_W-1:0]      tag_d   [SETS][2];
    logic [DATA_WIDTH-1:0] data_q  [SETS][2];
    logic [DATA_WIDTH-1:0] data_d  [SETS][2];
    // lru bit holds the index of the least recently used way of the set
    logic [SETS-1:0]       lru_q, lru_d;
    logic                  victim_q, victim_d;

    logic [SET_WIDTH-1:0]  idx;
    logic [TAG_W-1:0]      req_tag;
    logic                  req;
    logic [1:0]            match;
    logic                  hit_way;
    logic                  victim_sel;
    logic                  unused_addr_bits;

    assign idx              = address[SET_WIDTH+1:2];
    assign req_tag          = address[31:SET_WIDTH+2];
    assign req              = load | store;
    assign unused_addr_bits = ^address[1:0];
    assign match[0]         = valid_q[idx][0] && (tag_q[idx][0] == req_tag);
    assign match[1]         = valid_q[idx][1] && (tag_q[idx][1] == req_tag);
    assign hit_way          = ~match[0];
    assign victim_sel       = !valid_q[idx][0] ? 1'b0 :
                              !valid_q[idx][1] ? 1'b1 : lru_q[idx];

    always_comb begin
        state_d        = state_q;
        valid_d        = valid_q;
        dirty_d        = dirty_q;
        tag_d          = tag_q;
        data_d         = data_q;
        lru_d          = lru_q;
        victim_d       = victim_q;
        hit            = 1'b0;
        miss           = 1'b0;
        mem_write      = 1'b0;
        mem_read       = 1'b0;
        mem_addr       = '0;
        busy           = 1'b0;
        data_out       = '0;
        mem_write_data = '0;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    if (|match) begin
                        hit        = 1'b1;
                        data_out   = data_q[idx][hit_way];
                        lru_d[idx] = ~hit_way;
                        if (store) begin
                            data_d[idx][hit_way]  = data_in;
                            dirty_d[idx][hit_way] = 1'b1;
                        end
                    end else begin
                        miss     = 1'b1;
                        victim_d = victim_sel;
                        state_d  = (valid_q[idx][victim_sel] && dirty_q[idx][victim_sel])
                                   ? S_WRITEBACK : S_FILL;
                    end
                end
            end
            S_WRITEBACK: begin
                busy           = 1'b1;
                mem_write      = 1'b1;
                mem_addr       = {tag_q[idx][victim_q], idx, 2'b00};
                mem_write_data = data_q[idx][victim_q];
                if (mem_ready) begin
                    dirty_d[idx][victim_q] = 1'b0;
                    state_d                = S_FILL;
                end
            end
            S_FILL: begin
                busy     = 1'b1;
                mem_read = 1'b1;
                mem_addr = {address[31:2], 2'b00};
                if (mem_ready) begin
                    valid_d[idx][victim_q] = 1'b1;
                    dirty_d[idx][victim_q] = store;
                    tag_d[idx][victim_q]   = req_tag;
                    data_d[idx][victim_q]  = store ? data_in : mem_data;
                    lru_d[idx]             = ~victim_q;
                    state_d                = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            valid_q  <= '{default: '0};
            dirty_q  <= '{default: '0};
            lru_q    <= '0;
            victim_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            valid_q  <= valid_d;
            dirty_q  <= dirty_d;
            lru_q    <= lru_d;
            victim_q <= victim_d;
        end
    end

    // tag and data storage are qualified by valid, so they carry no reset
    always_ff @(posedge clk) begin
        tag_q  <= tag_d;
        data_q <= data_d;
    end

`ifdef L1_PERF_COUNTERS_EN
    logic [31:0] hit_count_q, hit_count_d;
    logic [31:0] miss_count_q, miss_count_d;

    always_comb begin
        hit_count_d  = hit_count_q + {31'd0, hit};
        miss_count_d = miss_count_q + {31'd0, miss};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hit_count_q  <= '0;
            miss_count_q <= '0;
        end else begin
            hit_count_q  <= hit_count_d;
            miss_count_q <= miss_count_d;
        end
    end

    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;
`endif

endmodule

// File: tb/tb_l1_set_assoc_cache.sv
// tb/tb_l1_set_assoc_cache.sv - scoreboard bench for l1_set_assoc_cache.
module tb_l1_set_assoc_cache;

    logic        clk = 1'b0;
    logic        rst_n, load, store, mem_ready;
    logic [31:0] address, data_in, mem_data;
    logic        hit, miss, mem_write, mem_read, busy;
    logic [31:0] mem_addr, data_out, mem_write_data;
`ifdef L1_PERF_COUNTERS_EN
    logic [31:0] hit_count, miss_count;
`endif

    int checks   = 0;
    int failures = 0;
    int m_hits   = 0;
    int m_misses = 0;

    logic [31:0] exp_hit_q[$];
    logic [31:0] exp_rd_q[$];
    logic [31:0] exp_wb_addr_q[$];
    logic [31:0] exp_wb_data_q[$];

    l1_set_assoc_cache #(.DATA_WIDTH(32), .SET_WIDTH(5)) dut (
        .clk(clk), .rst_n(rst_n), .load(load), .store(store), .address(address),
        .data_in(data_in), .mem_data(mem_data), .mem_ready(mem_ready),
        .hit(hit), .miss(miss), .mem_write(mem_write), .mem_read(mem_read),
        .mem_addr(mem_addr), .busy(busy), .data_out(data_out),
        .mem_write_data(mem_write_data)
`ifdef L1_PERF_COUNTERS_EN
        , .hit_count(hit_count), .miss_count(miss_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every hit and every completed memory handshake is matched against the scoreboard.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (hit) begin
                if (exp_hit_q.size() == 0) chk("unexpected_hit", 32'd1, 32'd0);
                else chk("hit_data", data_out, exp_hit_q.pop_front());
            end
            if (mem_write && mem_ready) begin
                if (exp_wb_addr_q.size() == 0) chk("unexpected_writeback", mem_addr, 32'hFFFF_FFFF);
                else begin
                    chk("wb_addr", mem_addr, exp_wb_addr_q.pop_front());
                    chk("wb_data", mem_write_data, exp_wb_data_q.pop_front());
                end
            end
            if (mem_read && mem_ready) begin
                if (exp_rd_q.size() == 0) chk("unexpected_fill", mem_addr, 32'hFFFF_FFFF);
                else chk("fill_addr", mem_addr, exp_rd_q.pop_front());
            end
            if (mem_read && mem_write) chk("rd_wr_exclusive", 32'd1, 32'd0);
        end
    end

    // One request: expected hit data / memory traffic are queued by the caller beforehand.
    task automatic access(input logic st, input logic ld, input logic [31:0] a,
                          input logic [31:0] din, input logic exp_miss, input logic [31:0] md);
        bit done = 0;
        store = st; load = ld; address = a; data_in = din;
        @(negedge clk);
        chk("miss_flag", {31'd0, miss}, {31'd0, exp_miss});
        if (exp_miss) begin
            m_misses++;
            tick();
            mem_ready = 1'b1; mem_data = md;
            for (int i = 0; i < 10 && !done; i++) begin
                @(negedge clk);
                if (hit) done = 1;
                else tick();
            end
            if (!done) chk("miss_timeout", 32'd0, 32'd1);
        end else begin
            chk("hit_no_mem", {30'd0, mem_read, mem_write}, 32'd0);
        end
        m_hits++;
        tick();
        load = 1'b0; store = 1'b0; mem_ready = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; load = 1'b0; store = 1'b0; mem_ready = 1'b0;
        address = '0; data_in = '0; mem_data = '0;
        tick(); tick();
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_outs", {27'd0, hit, miss, mem_write, mem_read, busy}, 32'd0);
        chk("reset_data_out", data_out, 32'd0);

        // clean fill of 0x40 with detailed state checks
        tick();
        load = 1'b1; address = 32'h40;
        exp_rd_q.push_back(32'h40); exp_hit_q.push_back(32'hDEADBEEF);
        @(negedge clk);
        chk("first_miss", {30'd0, hit, miss}, 32'd1);
        m_misses++;
        tick();
        @(negedge clk);
        chk("fill_busy", {30'd0, busy, mem_read}, 32'd3);
        chk("fill_addr_pre", mem_addr, 32'h40);
        tick();
        mem_ready = 1'b1; mem_data = 32'hDEADBEEF;
        tick();
        mem_ready = 1'b0;
        @(negedge clk);
        chk("after_fill", {30'd0, hit, busy}, 32'd2);
        m_hits++;
        tick();
        load = 1'b0;

        exp_hit_q.push_back(32'hDEADBEEF);
        access(1, 0, 32'h40, 32'h12345678, 0, 0);
        exp_hit_q.push_back(32'h12345678);
        access(0, 1, 32'h40, 0, 0, 0);
        exp_rd_q.push_back(32'hC0); exp_hit_q.push_back(32'hAAAA0000);
        access(0, 1, 32'hC0, 0, 1, 32'hAAAA0000);
        exp_wb_addr_q.push_back(32'h40); exp_wb_data_q.push_back(32'h12345678);
        exp_rd_q.push_back(32'h140); exp_hit_q.push_back(32'h55550000);
        access(0, 1, 32'h140, 0, 1, 32'h55550000);
        exp_hit_q.push_back(32'hAAAA0000);
        access(0, 1, 32'hC0, 0, 0, 0);
        exp_rd_q.push_back(32'h40); exp_hit_q.push_back(32'h12345678);
        access(0, 1, 32'h40, 0, 1, 32'h12345678);

        // stalled fill
        load = 1'b1; address = 32'h200;
        exp_rd_q.push_back(32'h200); exp_hit_q.push_back(32'h0BADF00D);
        @(negedge clk);
        chk("stall_miss", {31'd0, miss}, 32'd1);
        m_misses++;
        for (int i = 0; i < 10; i++) begin
            tick();
            @(negedge clk);
            chk("stall_state", {29'd0, busy, mem_read, hit}, 32'd6);
        end
        tick();
        mem_ready = 1'b1; mem_data = 32'h0BADF00D;
        tick();
        mem_ready = 1'b0;
        @(negedge clk);
        chk("stall_done_hit", {31'd0, hit}, 32'd1);
        m_hits++;
        tick();
        load = 1'b0;

        // reset while in FILL
        load = 1'b1; address = 32'h300;
        @(negedge clk);
        chk("pre_reset_miss", {31'd0, miss}, 32'd1);
        tick();
        rst_n = 1'b0; load = 1'b0;
        tick();
        rst_n = 1'b1;
        m_hits = 0; m_misses = 0;
        @(negedge clk);
        chk("reset_abort", {27'd0, hit, miss, mem_write, mem_read, busy}, 32'd0);
        tick();
        exp_rd_q.push_back(32'h40); exp_hit_q.push_back(32'h31415926);
        access(0, 1, 32'h40, 0, 1, 32'h31415926);

        // store miss installs data_in, store wins over load
        exp_rd_q.push_back(32'h204); exp_hit_q.push_back(32'h00000077);
        access(1, 0, 32'h204, 32'h77, 1, 32'h99);
        exp_hit_q.push_back(32'h00000077);
        access(0, 1, 32'h204, 0, 0, 0);
        exp_hit_q.push_back(32'h00000077);
        access(1, 1, 32'h204, 32'h88, 0, 0);
        exp_hit_q.push_back(32'h00000088);
        access(0, 1, 32'h204, 0, 0, 0);

        @(negedge clk);
        chk("idle_outs", {28'd0, hit, miss, mem_write, mem_read}, 32'd0);
`ifdef L1_PERF_COUNTERS_EN
        chk("hit_count", hit_count, m_hits);
        chk("miss_count", miss_count, m_misses);
`endif
        chk("queues_drained", exp_hit_q.size() + exp_rd_q.size() + exp_wb_addr_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

endmodule
